mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Two-master arbiter and sequencer for the single shared memory port of the RV32I core. Instruction fetch (IF) and the load/store unit (LS) request 32-bit accesses. The block picks one requester round-robin, drives the memory request until the memory grants it, waits for the response, and returns read data or a write acknowledge to the winner. One transaction is in flight at a time, and a response timeout guards against a hung memory.

## Interface
- TIMEOUT, 15: maximum cycles in RSP before the transaction is force-completed with an error; legal range 1..255.
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held high until if_rvalid is seen.
- if_addr  in  32  fetch byte address; word-aligned.
- if_rvalid  out  1  one-cycle completion pulse for fetch.
- if_rdata  out  32  fetch data; valid with if_rvalid.
- if_err  out  1  timeout flag; valid with if_rvalid.
- ls_req  in  1  LSU request; held high until ls_rvalid is seen.
- ls_wr  in  1  0 = store, 1 = load.
- ls_mask  in  4  byte-lane enables for stores.
- ls_addr  in  32  LSU byte address.
- ls_wdata  in  32  lane-aligned store data.
- ls_rvalid  out  1  one-cycle completion pulse for LSU (both load and store).
- ls_rdata  out  32  raw load word; valid with ls_rvalid; 0 for stores.
- ls_err  out  1  timeout flag; valid with ls_rvalid.
- mem_req  out  1  memory request.
- mem_wr  out  1  0 = write, 1 = read.
- mem_mask  out  4  byte enables; 4'b1111 for fetch and for loads.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  write data.
- mem_gnt  in  1  memory accepts the request this cycle.
- mem_rvalid  in  1  memory response valid.
- mem_rdata  in  32  memory read data.

## Operation
- FSM has four states: IDLE, REQ, RSP, DONE. All outputs are registered.
- IDLE:
  - No request: stay in IDLE.
  - One requester: grant it.
  - Both requesters: grant the one not granted last. The `last` bit resets to LS, so IF wins the first tie.
  - On grant: latch the winner's address, wr, mask, and wdata into the mem_* registers; set mem_req=1; record `owner`; go to REQ.
  - mem_rvalid is ignored in IDLE.
- REQ:
  - Hold mem_* stable with mem_req=1.
  - On mem_gnt: mem_req=0, clear the timeout counter, go to RSP.
  - mem_rvalid is ignored in REQ. Memory must respond at least one cycle after the grant.
- RSP:
  - The counter increments each cycle.
  - On mem_rvalid: capture mem_rdata into owner's rdata (0 if the owner issued a store), err=0, go to DONE.
  - If the counter reaches TIMEOUT with no mem_rvalid: owner's rdata=0, err=1, go to DONE.
  - If mem_rvalid and the timeout occur in the same cycle, mem_rvalid wins and err=0.
- DONE:
  - Owner's rvalid=1 for exactly this cycle; update `last`=owner; go to IDLE.
  - Requests are not sampled in DONE. This lets the requester drop or replace req after seeing rvalid without causing a double issue.
- The non-owner's rvalid, rdata, and err stay 0 throughout.
- Reset in any state:
  - State goes to IDLE and `last` to LS.
  - All outputs go to 0: mem_req, mem_wr, mem_mask, mem_addr, mem_wdata, both rvalid, both rdata, both err.
  - A late mem_rvalid arriving after reset is discarded.

## Timing
- The IDLE sample edge is cycle 0; mem_req goes high in cycle 1.
- mem_gnt in cycle g puts the FSM in RSP at cycle g+1.
- mem_rvalid in cycle r gives rvalid and rdata at cycle r+1 (DONE); IDLE is at r+2.
- Zero-wait memory (gnt in cycle 1, rvalid in cycle 2): rvalid in cycle 3, and the next mem_req no earlier than cycle 5. That is 4 cycles per access, back-to-back.
- Timeout: rvalid with err=1 is asserted TIMEOUT+1 cycles after RSP entry.
- Requests present in REQ, RSP, or DONE wait; they are never dropped.

## Test plan
- Reset, then only if_req with if_addr=0x0000_0010; memory gnt immediately and rvalid one cycle later with 0x0051_3093 -> mem_mask=4'b1111, mem_wr=1, if_rvalid pulses one cycle with if_rdata=0x0051_3093, if_err=0, ls_* outputs stay 0.
- LS store: ls_wr=0, ls_addr=0x104, ls_mask=4'b0100, ls_wdata=0x00AB_0000 -> mem_wr=0 with those exact mask, address, and data; ls_rvalid pulses with ls_rdata=0.
- if_req and ls_req both held high continuously out of reset -> grant order IF, LS, IF, LS, with exactly one rvalid per transaction and no duplicate mem_req.
- mem_gnt withheld for 3 cycles -> mem_req and mem_addr stay stable for all 4 REQ cycles; completion shifts by 3 cycles.
- mem_rvalid never asserted, TIMEOUT=15 -> owner's rvalid=1, err=1, rdata=0 exactly 16 cycles after RSP entry; the next request is then serviced normally.
- rst asserted while in RSP, then a stray mem_rvalid the following cycle -> all outputs 0, no rvalid pulse, and an IF-first tie-break on the next simultaneous requests.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-master (instruction fetch / load-store) arbiter for the shared memory port.
// Round-robin pick, one transaction in flight, response timeout, registered outputs.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   output logic        if_err,
   input  logic        ls_req,
   input  logic        ls_wr,
   input  logic [3:0]  ls_mask,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_rvalid,
   output logic [31:0] ls_rdata,
   output logic        ls_err,
   output logic        mem_req,
   output logic        mem_wr,
   output logic [3:0]  mem_mask,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   // state | meaning
   // IDLE  | waiting for a request; round-robin pick on a tie
   // REQ   | mem_req held with stable address/data until mem_gnt
   // RSP   | waiting for mem_rvalid while the timeout counter runs
   // DONE  | one-cycle completion pulse to the owner; requests not sampled

   typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

   localparam logic       OWN_IF = 1'b0;
   localparam logic       OWN_LS = 1'b1;
   localparam logic [7:0] TO_LIM = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;

   logic        mem_req_d, mem_wr_d;
   logic [3:0]  mem_mask_d;
   logic [31:0] mem_addr_d, mem_wdata_d;
   logic        if_rvalid_d, if_err_d, ls_rvalid_d, ls_err_d;
   logic [31:0] if_rdata_d, ls_rdata_d;

   logic        pick_ls;
   logic        rsp_end;
   logic [31:0] rsp_data;

   // LS wins only when IF is absent or IF was served last.
   assign pick_ls  = ls_req & (~if_req | (last_q == OWN_IF));
   assign rsp_end  = mem_rvalid | (cnt_q == TO_LIM);
   // Stores return zero; a timeout (no mem_rvalid) also returns zero.
   assign rsp_data = (mem_rvalid & mem_wr) ? mem_rdata : 32'h0;

   // Next-state and next-output computation.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req;
      mem_wr_d    = mem_wr;
      mem_mask_d  = mem_mask;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;
      if_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata;
      if_err_d    = if_err;
      ls_rvalid_d = 1'b0;
      ls_rdata_d  = ls_rdata;
      ls_err_d    = ls_err;

      case (state_q)
         IDLE: begin
            if (if_req | ls_req) begin
               owner_d   = pick_ls;
               mem_req_d = 1'b1;
               state_d   = REQ;
               if (pick_ls) begin
                  mem_wr_d    = ls_wr;
                  mem_mask_d  = ls_wr ? 4'b1111 : ls_mask;
                  mem_addr_d  = ls_addr;
                  mem_wdata_d = ls_wdata;
               end else begin
                  mem_wr_d    = 1'b1;
                  mem_mask_d  = 4'b1111;
                  mem_addr_d  = if_addr;
                  mem_wdata_d = 32'h0;
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               mem_req_d = 1'b0;
               cnt_d     = 8'd0;
               state_d   = RSP;
            end
         end
         RSP: begin
            if (rsp_end) begin
               state_d = DONE;
               if (owner_q == OWN_LS) begin
                  ls_rvalid_d = 1'b1;
                  ls_rdata_d  = rsp_data;
                  ls_err_d    = ~mem_rvalid;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = rsp_data;
                  if_err_d    = ~mem_rvalid;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            last_d     = owner_q;
            if_rdata_d = 32'h0;
            if_err_d   = 1'b0;
            ls_rdata_d = 32'h0;
            ls_err_d   = 1'b0;
            state_d    = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         owner_q   <= OWN_IF;
         last_q    <= OWN_LS;
         cnt_q     <= 8'd0;
         mem_req   <= 1'b0;
         mem_wr    <= 1'b0;
         mem_mask  <= 4'b0000;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         if_rvalid <= 1'b0;
         if_rdata  <= 32'h0;
         if_err    <= 1'b0;
         ls_rvalid <= 1'b0;
         ls_rdata  <= 32'h0;
         ls_err    <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         mem_req   <= mem_req_d;
         mem_wr    <= mem_wr_d;
         mem_mask  <= mem_mask_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
         if_rvalid <= if_rvalid_d;
         if_rdata  <= if_rdata_d;
         if_err    <= if_err_d;
         ls_rvalid <= ls_rvalid_d;
         ls_rdata  <= ls_rdata_d;
         ls_err    <= ls_err_d;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level round-robin / timing model.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 15;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        if_rvalid, if_err;
   logic [31:0] if_rdata;
   logic        ls_req = 1'b0, ls_wr = 1'b0;
   logic [3:0]  ls_mask = '0;
   logic [31:0] ls_addr = '0, ls_wdata = '0;
   logic        ls_rvalid, ls_err;
   logic [31:0] ls_rdata;
   logic        mem_req, mem_wr;
   logic [3:0]  mem_mask;
   logic [31:0] mem_addr, mem_wdata;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rvalid(if_rvalid), .if_rdata(if_rdata), .if_err(if_err),
      .ls_req(ls_req), .ls_wr(ls_wr), .ls_mask(ls_mask), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata), .ls_err(ls_err),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_mask(mem_mask), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   int   cyc = 0;
   int   if_pulses = 0, ls_pulses = 0, req_rises = 0;
   logic req_prev = 1'b0;
   int   n_vec = 0, n_err = 0;

   always @(posedge clk) cyc++;

   // Event counters (sample the value held during the cycle that just ended).
   always @(posedge clk) begin
      if (if_rvalid === 1'b1) if_pulses++;
      if (ls_rvalid === 1'b1) ls_pulses++;
      if (mem_req === 1'b1 && req_prev !== 1'b1) req_rises++;
      req_prev = mem_req;
   end

   // Results of the most recent memory transaction.
   int          x_req, x_gnt, x_done;
   logic [31:0] x_a, x_wd, x_rd;
   logic        x_w, x_err;
   logic [3:0]  x_m;
   bit          x_stable, x_if, x_ls, x_onz, x_hung;

   // Memory-side driver: waits for mem_req, stalls gw cycles, grants, answers rw
   // cycles after the grant (or never when nr), then waits for the completion pulse.
   task automatic xact(input int gw, input int rw, input bit nr, input logic [31:0] rd);
      x_hung = 0; x_stable = 1; x_if = 0; x_ls = 0; x_rd = '0; x_err = 0; x_onz = 0;
      x_req = 0; x_gnt = 0; x_done = 0; x_a = '0; x_w = 0; x_m = '0; x_wd = '0;
      for (int t = 0; t < 50 && mem_req !== 1'b1; t++) @(negedge clk);
      if (mem_req !== 1'b1) begin x_hung = 1; return; end
      x_req = cyc; x_a = mem_addr; x_w = mem_wr; x_m = mem_mask; x_wd = mem_wdata;
      for (int k = 0; k < gw; k++) begin
         @(negedge clk);
         if (mem_req !== 1'b1 || mem_addr !== x_a || mem_wr !== x_w || mem_mask !== x_m || mem_wdata !== x_wd)
            x_stable = 0;
      end
      mem_gnt = 1'b1; x_gnt = cyc;
      @(negedge clk);
      mem_gnt = 1'b0;
      if (mem_req !== 1'b0) x_stable = 0;
      if (!nr) begin
         for (int k = 1; k < rw; k++) @(negedge clk);
         mem_rvalid = 1'b1; mem_rdata = rd;
         @(negedge clk);
         mem_rvalid = 1'b0; mem_rdata = $urandom();
      end
      for (int t = 0; t < 40 && !(if_rvalid === 1'b1 || ls_rvalid === 1'b1); t++) @(negedge clk);
      if (!(if_rvalid === 1'b1 || ls_rvalid === 1'b1)) begin x_hung = 1; return; end
      x_done = cyc; x_if = if_rvalid; x_ls = ls_rvalid;
      if (x_if) begin
         x_rd = if_rdata; x_err = if_err;
         x_onz = (ls_rvalid !== 1'b0) || (ls_err !== 1'b0) || (ls_rdata !== 32'h0);
      end else begin
         x_rd = ls_rdata; x_err = ls_err;
         x_onz = (if_rvalid !== 1'b0) || (if_err !== 1'b0) || (if_rdata !== 32'h0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      n_vec++; if ({mem_req, mem_wr, mem_mask, mem_addr, mem_wdata} !== '0) begin n_err++;
         $display("FAIL reset_mem got=%0h exp=0", {mem_req, mem_wr, mem_mask, mem_addr, mem_wdata}); end
      n_vec++; if ({if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, ls_err} !== '0) begin n_err++;
         $display("FAIL reset_rsp got=%0h exp=0", {if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, ls_err}); end
      rst = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL idle_no_req got=%0b exp=0", mem_req); end
   endtask

   task automatic test_if_fetch();
      int c, p_if, p_ls;
      p_if = if_pulses; p_ls = ls_pulses;
      if_addr = 32'h0000_0010; if_req = 1'b1; c = cyc;
      xact(0, 1, 0, 32'h0051_3093);
      if_req = 1'b0;
      n_vec++; if (x_hung) begin n_err++; $display("FAIL fetch_hang got=hung exp=done"); return; end
      n_vec++; if (x_req !== c + 1) begin n_err++; $display("FAIL fetch_req_cyc got=%0d exp=%0d", x_req, c + 1); end
      n_vec++; if ({x_w, x_m, x_a} !== {1'b1, 4'b1111, 32'h10}) begin n_err++;
         $display("FAIL fetch_mem got=%0h exp=%0h", {x_w, x_m, x_a}, {1'b1, 4'b1111, 32'h10}); end
      n_vec++; if ({x_if, x_ls, x_rd, x_err} !== {2'b10, 32'h0051_3093, 1'b0}) begin n_err++;
         $display("FAIL fetch_rsp got=%0h exp=%0h", {x_if, x_ls, x_rd, x_err}, {2'b10, 32'h0051_3093, 1'b0}); end
      n_vec++; if (x_done !== x_gnt + 2) begin n_err++; $display("FAIL fetch_lat got=%0d exp=%0d", x_done, x_gnt + 2); end
      n_vec++; if (x_onz) begin n_err++; $display("FAIL fetch_ls_quiet got=1 exp=0"); end
      @(negedge clk);
      n_vec++; if (if_rvalid !== 1'b0) begin n_err++; $display("FAIL fetch_pulse_len got=%0b exp=0", if_rvalid); end
      repeat (3) @(negedge clk);
      n_vec++; if (if_pulses - p_if !== 1 || ls_pulses - p_ls !== 0) begin n_err++;
         $display("FAIL fetch_pulse_cnt got=%0d/%0d exp=1/0", if_pulses - p_if, ls_pulses - p_ls); end
   endtask

   task automatic test_ls_store();
      ls_wr = 1'b0; ls_addr = 32'h104; ls_mask = 4'b0100; ls_wdata = 32'h00AB_0000; ls_req = 1'b1;
      xact(0, 2, 0, 32'hDEAD_BEEF);
      ls_req = 1'b0;
      n_vec++; if (x_hung) begin n_err++; $display("FAIL store_hang got=hung exp=done"); return; end
      n_vec++; if ({x_w, x_m, x_a, x_wd} !== {1'b0, 4'b0100, 32'h104, 32'h00AB_0000}) begin n_err++;
         $display("FAIL store_mem got=%0h exp=%0h", {x_w, x_m, x_a, x_wd}, {1'b0, 4'b0100, 32'h104, 32'h00AB_0000}); end
      n_vec++; if ({x_if, x_ls, x_rd, x_err} !== {2'b01, 32'h0, 1'b0}) begin n_err++;
         $display("FAIL store_rsp got=%0h exp=%0h", {x_if, x_ls, x_rd, x_err}, {2'b01, 32'h0, 1'b0}); end
      n_vec++; if (x_done !== x_gnt + 3 || x_onz) begin n_err++;
         $display("FAIL store_lat got=%0d exp=%0d", x_done, x_gnt + 3); end
   endtask

   task automatic test_back_to_back();
      int p_if, p_ls, p_rq, prev;
      rst = 1'b1;
      if_addr = 32'h200; ls_addr = 32'h300; ls_wr = 1'b1; ls_mask = 4'b0001;
      if_req = 1'b1; ls_req = 1'b1;
      repeat (2) @(negedge clk);
      p_if = if_pulses; p_ls = ls_pulses; p_rq = req_rises;
      rst = 1'b0; prev = 0;
      for (int i = 0; i < 4; i++) begin
         xact(0, 1, 0, 32'h1000 + i);
         n_vec++; if (x_hung) begin n_err++; $display("FAIL b2b_hang got=hung exp=done idx=%0d", i); break; end
         n_vec++; if ({x_if, x_ls} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin n_err++;
            $display("FAIL b2b_order idx=%0d got=%0b exp=%0b", i, {x_if, x_ls}, (i % 2 == 0) ? 2'b10 : 2'b01); end
         n_vec++; if (x_a !== ((i % 2 == 0) ? 32'h200 : 32'h300) || x_rd !== 32'h1000 + i) begin n_err++;
            $display("FAIL b2b_data idx=%0d got=%0h/%0h", i, x_a, x_rd); end
         if (i > 0) begin
            n_vec++; if (x_req - prev !== 2) begin n_err++; $display("FAIL b2b_gap idx=%0d got=%0d exp=2", i, x_req - prev); end
         end
         prev = x_done;
      end
      if_req = 1'b0; ls_req = 1'b0;
      repeat (4) @(negedge clk);
      n_vec++; if (if_pulses - p_if !== 2 || ls_pulses - p_ls !== 2 || req_rises - p_rq !== 4) begin n_err++;
         $display("FAIL b2b_counts got=%0d/%0d/%0d exp=2/2/4", if_pulses - p_if, ls_pulses - p_ls, req_rises - p_rq); end
   endtask

   task automatic test_gnt_stall();
      if_addr = 32'h0000_0444; if_req = 1'b1;
      xact(3, 1, 0, 32'hCAFE_0001);
      if_req = 1'b0;
      n_vec++; if (x_hung) begin n_err++; $display("FAIL stall_hang got=hung exp=done"); return; end
      n_vec++; if (!x_stable) begin n_err++; $display("FAIL stall_stable got=0 exp=1"); end
      n_vec++; if (x_done - x_req !== 5) begin n_err++; $display("FAIL stall_lat got=%0d exp=5", x_done - x_req); end
      n_vec++; if ({x_if, x_rd, x_err} !== {1'b1, 32'hCAFE_0001, 1'b0}) begin n_err++;
         $display("FAIL stall_rsp got=%0h exp=%0h", {x_if, x_rd, x_err}, {1'b1, 32'hCAFE_0001, 1'b0}); end
   endtask

   task automatic test_timeout();
      ls_wr = 1'b1; ls_addr = 32'h0000_0800; ls_mask = 4'b0011; ls_req = 1'b1;
      xact(1, 1, 1, 32'h0);
      ls_req = 1'b0;
      n_vec++; if (x_hung) begin n_err++; $display("FAIL to_hang got=hung exp=done"); return; end
      n_vec++; if ({x_ls, x_rd, x_err} !== {1'b1, 32'h0, 1'b1}) begin n_err++;
         $display("FAIL to_rsp got=%0h exp=%0h", {x_ls, x_rd, x_err}, {1'b1, 32'h0, 1'b1}); end
      n_vec++; if (x_done - (x_gnt + 1) !== TIMEOUT + 1) begin n_err++;
         $display("FAIL to_lat got=%0d exp=%0d", x_done - (x_gnt + 1), TIMEOUT + 1); end
      if_addr = 32'h0000_0020; if_req = 1'b1;
      xact(0, 3, 0, 32'h7777_0000);
      if_req = 1'b0;
      n_vec++; if (x_hung || {x_if, x_rd, x_err} !== {1'b1, 32'h7777_0000, 1'b0} || x_done !== x_gnt + 4) begin n_err++;
         $display("FAIL to_recover got=%0h lat=%0d", {x_if, x_rd, x_err}, x_done - x_gnt); end
   endtask

   task automatic test_reset_in_rsp();
      int p_if, p_ls;
      if_addr = 32'h40; if_req = 1'b1;
      for (int t = 0; t < 50 && mem_req !== 1'b1; t++) @(negedge clk);
      n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL rrsp_req got=0 exp=1"); end
      mem_gnt = 1'b1;
      @(negedge clk);
      mem_gnt = 1'b0;
      @(negedge clk);
      rst = 1'b1; if_req = 1'b0;
      p_if = if_pulses; p_ls = ls_pulses;
      @(negedge clk);
      rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
      n_vec++; if ({mem_req, mem_wr, mem_mask, mem_addr, mem_wdata, if_rvalid, if_rdata, if_err, ls_rvalid, ls_rdata, ls_err} !== '0) begin
         n_err++; $display("FAIL rrsp_zero got=nonzero exp=0"); end
      @(negedge clk);
      mem_rvalid = 1'b0;
      repeat (3) @(negedge clk);
      n_vec++; if (if_pulses - p_if !== 0 || ls_pulses - p_ls !== 0 || if_rdata !== 32'h0) begin n_err++;
         $display("FAIL rrsp_stray got=%0d/%0d exp=0/0", if_pulses - p_if, ls_pulses - p_ls); end
      if_addr = 32'h80; ls_addr = 32'h90; ls_wr = 1'b0; ls_mask = 4'b1000; ls_wdata = 32'h5500_0000;
      if_req = 1'b1; ls_req = 1'b1;
      xact(0, 1, 0, 32'hABCD_0123);
      if_req = 1'b0;
      n_vec++; if (x_hung || {x_if, x_ls, x_a} !== {2'b10, 32'h80}) begin n_err++;
         $display("FAIL rrsp_tiebreak got=%0h exp=%0h", {x_if, x_ls, x_a}, {2'b10, 32'h80}); end
      xact(0, 1, 0, 32'h0);
      ls_req = 1'b0;
      n_vec++; if (x_hung || {x_ls, x_a, x_m} !== {1'b1, 32'h90, 4'b1000}) begin n_err++;
         $display("FAIL rrsp_second got=%0h exp=%0h", {x_ls, x_a, x_m}, {1'b1, 32'h90, 4'b1000}); end
   endtask

   task automatic test_random();
      bit          pend_if, pend_ls, last_ls, win_ls, to_case;
      int          gw, rw, prev_done, exp_done;
      logic [31:0] rd, exp_a, exp_rd;
      logic [3:0]  exp_m;
      logic        exp_w;
      if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pend_if = 0; pend_ls = 0; last_ls = 1; prev_done = cyc - 1;
      for (int i = 0; i < 40; i++) begin
         if (!pend_if && $urandom_range(0, 1) == 1) begin
            pend_if = 1; if_addr = $urandom() & 32'hFFFF_FFFC; if_req = 1'b1;
         end
         if (!pend_ls && (!pend_if || $urandom_range(0, 1) == 1)) begin
            pend_ls = 1; ls_wr = 1'($urandom_range(0, 1)); ls_mask = 4'($urandom_range(1, 15));
            ls_addr = $urandom(); ls_wdata = $urandom(); ls_req = 1'b1;
         end
         win_ls  = pend_ls && (!pend_if || !last_ls);
         gw      = $urandom_range(0, 3);
         rw      = $urandom_range(1, 4);
         to_case = ($urandom_range(0, 7) == 0);
         rd      = $urandom();
         exp_a   = win_ls ? ls_addr : if_addr;
         exp_w   = win_ls ? ls_wr : 1'b1;
         exp_m   = (win_ls && !ls_wr) ? ls_mask : 4'b1111;
         exp_rd  = (to_case || !exp_w) ? 32'h0 : rd;
         xact(gw, rw, to_case, rd);
         n_vec++; if (x_hung) begin n_err++; $display("FAIL rnd_hang idx=%0d got=hung exp=done", i); break; end
         exp_done = to_case ? x_gnt + TIMEOUT + 2 : x_gnt + rw + 1;
         n_vec++; if ({x_if, x_ls} !== {!win_ls, win_ls}) begin n_err++;
            $display("FAIL rnd_owner idx=%0d got=%0b exp=%0b", i, {x_if, x_ls}, {!win_ls, win_ls}); end
         n_vec++; if ({x_a, x_w, x_m} !== {exp_a, exp_w, exp_m}) begin n_err++;
            $display("FAIL rnd_mem idx=%0d got=%0h exp=%0h", i, {x_a, x_w, x_m}, {exp_a, exp_w, exp_m}); end
         if (win_ls && !ls_wr) begin
            n_vec++; if (x_wd !== ls_wdata) begin n_err++; $display("FAIL rnd_wdata idx=%0d got=%0h exp=%0h", i, x_wd, ls_wdata); end
         end
         n_vec++; if ({x_rd, x_err} !== {exp_rd, to_case}) begin n_err++;
            $display("FAIL rnd_rsp idx=%0d got=%0h exp=%0h", i, {x_rd, x_err}, {exp_rd, to_case}); end
         n_vec++; if (x_done !== exp_done) begin n_err++; $display("FAIL rnd_lat idx=%0d got=%0d exp=%0d", i, x_done, exp_done); end
         n_vec++; if (x_req !== prev_done + 2) begin n_err++; $display("FAIL rnd_issue idx=%0d got=%0d exp=%0d", i, x_req, prev_done + 2); end
         n_vec++; if (!x_stable || x_onz) begin n_err++; $display("FAIL rnd_misc idx=%0d stable=%0b other=%0b", i, x_stable, x_onz); end
         last_ls = win_ls;
         if (win_ls) begin pend_ls = 0; ls_req = 1'b0; end
         else begin pend_if = 0; if_req = 1'b0; end
         prev_done = x_done;
      end
      if_req = 1'b0; ls_req = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      @(negedge clk);
      test_reset();
      test_if_fetch();
      test_ls_store();
      test_back_to_back();
      test_gnt_stall();
      test_timeout();
      test_reset_in_rsp();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
